// File: rtl/alu_md.sv
// ALU with iterative multiply/divide and HI/LO registers; single-cycle ops respond 1 cycle after acceptance, MULTU/DIVU WIDTH+1 cycles.
// in_ready = !busy while a multi-cycle op iterates; flush aborts it. Define ALU_MD_DIV_EN to build the restoring divider.
module alu_md #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] data_out1,
    input  logic [WIDTH-1:0] alu_op_q,
    input  logic [1:0]       sel_a,
    input  logic [1:0]       sel_b,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;
    localparam logic [3:0] OP_LUI   = 4'd15;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   result_q;
    logic               out_valid_q, zero_q, overflow_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] work_q;

    logic [WIDTH-1:0]   a_sel, b_sel;
    logic [WIDTH-1:0]   alu_res_d;
    logic               alu_ovf_d;
    logic [WIDTH-1:0]   add_res, sub_res;
    logic [SH_W-1:0]    shamt;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic               last_iter;

    assign busy      = (state_q != IDLE);
    assign in_ready  = !busy;
    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

    always_comb begin
        a_sel = operand_a;
        if (sel_a == 2'b10)      a_sel = data_out1;
        else if (sel_a == 2'b11) a_sel = alu_op_q;
        b_sel = operand_b;
        if (sel_b == 2'b10)      b_sel = data_out1;
        else if (sel_b == 2'b11) b_sel = alu_op_q;
    end

    assign add_res = a_sel + b_sel;
    assign sub_res = a_sel - b_sel;
    assign shamt   = b_sel[SH_W-1:0];

    always_comb begin
        alu_res_d = '0;
        alu_ovf_d = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res_d = add_res;
                alu_ovf_d = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (add_res[WIDTH-1] != a_sel[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_d = sub_res;
                alu_ovf_d = (a_sel[WIDTH-1] != b_sel[WIDTH-1]) && (sub_res[WIDTH-1] != a_sel[WIDTH-1]);
            end
            OP_AND:  alu_res_d = a_sel & b_sel;
            OP_OR:   alu_res_d = a_sel | b_sel;
            OP_XOR:  alu_res_d = a_sel ^ b_sel;
            OP_NOR:  alu_res_d = ~(a_sel | b_sel);
            OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(a_sel) < $signed(b_sel))};
            OP_SLTU: alu_res_d = {{(WIDTH-1){1'b0}}, (a_sel < b_sel)};
            OP_SLL:  alu_res_d = a_sel << shamt;
            OP_SRL:  alu_res_d = a_sel >> shamt;
            OP_SRA:  alu_res_d = $signed(a_sel) >>> shamt;
            OP_MFHI: alu_res_d = hi_q;
            OP_MFLO: alu_res_d = lo_q;
            OP_LUI:  alu_res_d = b_sel << (WIDTH / 2);
            default: alu_res_d = '0;
        endcase
    end

    // Shift-add step: work_q holds {partial HI, remaining multiplier bits}
    assign mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, (work_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign mul_next  = {mul_sum, work_q[WIDTH-1:1]};
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef ALU_MD_DIV_EN
    // Restoring step: work_q holds {remainder, dividend shifting into quotient}
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  work_q[WIDTH-2:0], 1'b1};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            opnd_q      <= '0;
            work_q      <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && !flush) begin
                        if (op == OP_MULTU) begin
                            opnd_q  <= a_sel;
                            work_q  <= {{WIDTH{1'b0}}, b_sel};
                            cnt_q   <= '0;
                            state_q <= MUL;
                        end else if (op == OP_DIVU) begin
`ifdef ALU_MD_DIV_EN
                            if (b_sel == '0) begin
                                hi_q        <= a_sel;
                                lo_q        <= '1;
                                result_q    <= '1;
                                zero_q      <= 1'b0;
                                overflow_q  <= 1'b1;
                                out_valid_q <= 1'b1;
                            end else begin
                                opnd_q  <= b_sel;
                                work_q  <= {{WIDTH{1'b0}}, a_sel};
                                cnt_q   <= '0;
                                state_q <= DIV;
                            end
`else
                            result_q    <= '0;
                            zero_q      <= 1'b1;
                            overflow_q  <= 1'b1;
                            out_valid_q <= 1'b1;
`endif
                        end else begin
                            result_q    <= alu_res_d;
                            zero_q      <= (alu_res_d == '0);
                            overflow_q  <= alu_ovf_d;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        work_q <= mul_next;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (last_iter) begin
                            hi_q        <= mul_next[2*WIDTH-1:WIDTH];
                            lo_q        <= mul_next[WIDTH-1:0];
                            result_q    <= mul_next[WIDTH-1:0];
                            zero_q      <= (mul_next[WIDTH-1:0] == '0);
                            overflow_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
`ifdef ALU_MD_DIV_EN
                DIV: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        work_q <= div_next;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (last_iter) begin
                            hi_q        <= div_next[2*WIDTH-1:WIDTH];
                            lo_q        <= div_next[WIDTH-1:0];
                            result_q    <= div_next[WIDTH-1:0];
                            zero_q      <= (div_next[WIDTH-1:0] == '0);
                            overflow_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md (WIDTH=32); expectations follow ALU_MD_DIV_EN.
module tb_alu_md;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] operand_a, operand_b, data_out1, alu_op_q;
    logic [1:0]  sel_a, sel_b;
    logic        flush;
    logic [31:0] result;
    logic        out_valid, zero, overflow, busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_md #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .operand_a(operand_a), .operand_b(operand_b),
        .data_out1(data_out1), .alu_op_q(alu_op_q), .sel_a(sel_a), .sel_b(sel_b),
        .flush(flush), .result(result), .out_valid(out_valid), .zero(zero),
        .overflow(overflow), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        step();
        in_valid  = 1'b0;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h5A5A_5A5A;
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic ovf);
        chk({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".result"}, result, res);
        chk({tag, ".zero"}, zero, (res == 32'd0));
        chk({tag, ".ovf"}, overflow, ovf);
    endtask

    task automatic wait_multi(input string tag);
        for (int i = 1; i <= 32; i++) begin
            chk({tag, ".busy"}, {busy, in_ready, out_valid}, 3'b100);
            step();
        end
    endtask

    logic [31:0] exp_hi, exp_lo;
    logic        seen;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; op = 4'd0; flush = 1'b0;
        operand_a = '0; operand_b = '0; data_out1 = '0; alu_op_q = '0;
        sel_a = 2'b00; sel_b = 2'b00;
        step(); step();
        chk("rst.busy", busy, 1'b0);
        chk("rst.ready", in_ready, 1'b1);
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.result", result, 32'd0);
        chk("rst.zero", zero, 1'b0);
        chk("rst.ovf", overflow, 1'b0);
        reset_n = 1'b1;
        step();

        issue(4'd0, 32'h7FFF_FFFF, 32'd1);
        check_out("add_ovf", 32'h8000_0000, 1'b1);
        step();
        chk("idle.valid", out_valid, 1'b0);

        // Forwarding: a from EX (5), b from MEM (3)
        sel_a = 2'b11; alu_op_q = 32'd5; operand_a = 32'd9;
        sel_b = 2'b10; data_out1 = 32'd3;
        in_valid = 1'b1; op = 4'd1;
        step();
        in_valid = 1'b0; sel_a = 2'b00; sel_b = 2'b00; alu_op_q = 32'd100;
        check_out("fwd_sub", 32'd2, 1'b0);

        // Back-to-back acceptance
        in_valid = 1'b1; op = 4'd2; operand_a = 32'hF0F0; operand_b = 32'hFF00;
        step();
        check_out("b2b_and", 32'h0000_F000, 1'b0);
        op = 4'd3; operand_a = 32'hF0F0; operand_b = 32'h0F0F;
        step();
        check_out("b2b_or", 32'h0000_FFFF, 1'b0);
        in_valid = 1'b0;

        issue(4'd4, 32'h1234_5678, 32'h1234_5678); check_out("xor_zero", 32'd0, 1'b0);
        issue(4'd5, 32'd0, 32'd0);                 check_out("nor", 32'hFFFF_FFFF, 1'b0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd1);         check_out("slt", 32'd1, 1'b0);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1);         check_out("sltu", 32'd0, 1'b0);
        issue(4'd8, 32'd1, 32'd31);                check_out("sll31", 32'h8000_0000, 1'b0);
        issue(4'd8, 32'd1, 32'h21);                check_out("sll_amt", 32'd2, 1'b0);
        issue(4'd9, 32'h8000_0000, 32'd4);         check_out("srl", 32'h0800_0000, 1'b0);
        issue(4'd10, 32'h8000_0000, 32'd4);        check_out("sra", 32'hF800_0000, 1'b0);
        issue(4'd15, 32'd0, 32'h1234);             check_out("lui", 32'h1234_0000, 1'b0);
        issue(4'd1, 32'h8000_0000, 32'd1);         check_out("sub_ovf", 32'h7FFF_FFFF, 1'b1);

        issue(4'd11, 32'hFFFF_FFFF, 32'd2);
        wait_multi("mul");
        check_out("multu", 32'hFFFF_FFFE, 1'b0);
        chk("multu.ready", in_ready, 1'b1);
        issue(4'd13, 32'd0, 32'd0); check_out("mfhi_mul", 32'd1, 1'b0);
        issue(4'd14, 32'd0, 32'd0); check_out("mflo_mul", 32'hFFFF_FFFE, 1'b0);

`ifdef ALU_MD_DIV_EN
        issue(4'd12, 32'd100, 32'd7);
        wait_multi("div");
        check_out("divu", 32'd14, 1'b0);
        issue(4'd13, 32'd0, 32'd0); check_out("mfhi_div", 32'd2, 1'b0);
        issue(4'd12, 32'd55, 32'd0);
        check_out("divu_b0", 32'hFFFF_FFFF, 1'b1);
        issue(4'd13, 32'd0, 32'd0); check_out("mfhi_b0", 32'd55, 1'b0);
        exp_hi = 32'd55; exp_lo = 32'hFFFF_FFFF;
`else
        issue(4'd12, 32'd100, 32'd7);
        check_out("divu_off", 32'd0, 1'b1);
        chk("divu_off.busy", busy, 1'b0);
        issue(4'd13, 32'd0, 32'd0); check_out("mfhi_off", 32'd1, 1'b0);
        exp_hi = 32'd1; exp_lo = 32'hFFFF_FFFE;
`endif

        // Flush MULTU in its 10th cycle
        issue(4'd11, 32'd3, 32'd5);
        for (int i = 1; i < 10; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush.busy", busy, 1'b0);
        chk("flush.ready", in_ready, 1'b1);
        seen = out_valid;
        for (int i = 0; i < 40; i++) begin
            step();
            seen = seen | out_valid;
        end
        chk("flush.no_valid", seen, 1'b0);
        issue(4'd14, 32'd0, 32'd0); check_out("flush.mflo", exp_lo, 1'b0);
        issue(4'd13, 32'd0, 32'd0); check_out("flush.mfhi", exp_hi, 1'b0);

        // flush in the same cycle as a request blocks acceptance
        flush = 1'b1;
        issue(4'd0, 32'd1, 32'd1);
        flush = 1'b0;
        chk("flush_req.valid", out_valid, 1'b0);

        // Reset mid-operation
`ifdef ALU_MD_DIV_EN
        issue(4'd12, 32'd100, 32'd7);
`else
        issue(4'd11, 32'd3, 32'd5);
`endif
        for (int i = 1; i < 5; i++) step();
        chk("pre_rst.busy", busy, 1'b1);
        reset_n = 1'b0;
        step();
        chk("mid_rst.busy", busy, 1'b0);
        chk("mid_rst.valid", out_valid, 1'b0);
        chk("mid_rst.result", result, 32'd0);
        reset_n = 1'b1;
        issue(4'd13, 32'd0, 32'd0); check_out("mid_rst.hi", 32'd0, 1'b0);
        issue(4'd14, 32'd0, 32'd0); check_out("mid_rst.lo", 32'd0, 1'b0);
        step();
        chk("end.valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64, even).
REQ-002 SHALL have parameter CNT_W, default 6, iteration-counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  in  1  rising-edge clock; the only clock.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  unit can accept a request; an op is accepted when in_valid && in_ready at a rising edge.
REQ-007 op  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MULTU, 12 DIVU, 13 MFHI, 14 MFLO, 15 LUI.
REQ-008 operand_a, operand_b  in  WIDTH  register-file operands.
REQ-009 data_out1, alu_op_q  in  WIDTH  forwarded values from MEM and EX stages.
REQ-010 sel_a, sel_b  in  2  forwarding select: 2'b10 data_out1, 2'b11 alu_op_q, otherwise register operand.
REQ-011 flush  in  1  abort of any accepted or in-flight op.
REQ-012 result  out  WIDTH  registered result.
REQ-013 out_valid  out  1  one-cycle pulse qualifying result, zero, overflow.
REQ-014 zero  out  1  result == 0.
REQ-015 overflow  out  1  signed overflow (ADD/SUB) or divide-by-zero (DIVU).
REQ-016 busy  out  1  multi-cycle op in progress; in_ready SHALL equal !busy.

Function
REQ-017 Operands SHALL be selected per REQ-010 and captured at acceptance; later input changes SHALL not affect an accepted op.
REQ-018 Single-cycle ops (0-10, 13-15) SHALL assert out_valid exactly one cycle after acceptance; back-to-back acceptance SHALL give back-to-back out_valid.
REQ-019 Shifts SHALL use b[log2(WIDTH)-1:0] as amount, a as data; SLT signed, SLTU unsigned, result 0 or 1; LUI SHALL give b shifted left by WIDTH/2.
REQ-020 ADD/SUB SHALL wrap modulo 2^WIDTH and set overflow on two's-complement overflow; overflow SHALL be 0 for all other ops except REQ-025.
REQ-021 FSM states IDLE, MUL, DIV; MULTU/DIVU accepted in IDLE SHALL enter MUL/DIV and assert busy the next cycle.
REQ-022 MULTU SHALL be iterative shift-add, WIDTH iterations; on completion {HI,LO} = a*b unsigned, out_valid pulses with result = LO, state returns to IDLE.
REQ-023 DIVU SHALL be iterative restoring, WIDTH iterations; on completion LO = a/b, HI = a%b, out_valid pulses with result = LO.
REQ-024 Multi-cycle latency SHALL be WIDTH+1 cycles from acceptance to out_valid; in_ready SHALL rise in the out_valid cycle.
REQ-025 DIVU with b == 0 SHALL complete in 1 cycle without entering DIV: HI = a, LO = all ones, overflow = 1.
REQ-026 MFHI/MFLO SHALL return HI/LO as updated by all previously completed ops.
REQ-027 flush SHALL return FSM to IDLE, suppress any pending out_valid, and leave HI/LO unchanged; flush with in_valid in the same cycle SHALL not accept.

Reset
REQ-028 While reset_n is low at a rising edge: state IDLE, busy 0, out_valid 0, result 0, zero 0, overflow 0, HI 0, LO 0, counter 0; reset mid-operation SHALL discard the op.

Configuration
REQ-029 Macro ALU_MD_DIV_EN: defined -> divider built per REQ-023/025; undefined -> no divider logic, DIVU completes in 1 cycle with result 0, HI/LO unchanged, overflow = 1.

Verification
REQ-030 ADD a=0x7FFFFFFF, b=1 -> next cycle out_valid, result 0x80000000, overflow 1, zero 0.
REQ-031 sel_a=2'b11, alu_op_q=5, operand_a=9, sel_b=2'b10, data_out1=3, SUB -> result 2.
REQ-032 MULTU a=0xFFFFFFFF, b=2 -> busy 32 cycles, out_valid at cycle 33, result 0xFFFFFFFE; then MFHI -> 1.
REQ-033 DIVU a=100, b=7 -> result 14 at cycle 33; MFHI -> 2; DIVU b=0 -> next cycle LO 0xFFFFFFFF, overflow 1.
REQ-034 MULTU accepted, flush at cycle 10 -> no out_valid, in_ready 1 next cycle, MFLO returns prior LO.
REQ-035 reset_n low during DIV cycle 5 -> next cycle busy 0, out_valid 0, HI=LO=0.
